// File: rtl/dll_tx_arbiter_pkg.sv
// Shared DLL transmit-side types: link-state encoding, beat width and the
// arbiter state type.
package dll_tx_arbiter_pkg;

  localparam int DLL_BEAT_W = 256;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_ACTIVE   = 2'd3
  } dlcm_state_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_TLP  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dll_pipe_out_reg.sv
// Single-entry valid/ready output register for PIPE-facing beat streams.
// The producer may load only while stage_ready_o is high.
module dll_pipe_out_reg #(
  parameter int W = 256
) (
  input  logic         sclk,
  input  logic         srst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         pipe_ready_i,
  output logic         stage_ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  assign stage_ready_o = !valid_o || pipe_ready_i;

  // Data is left untouched on drain so the bus does not toggle needlessly.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (pipe_ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/dll_tx_arbiter.sv
// Merges DLLPs and TLPs onto the DLL-to-PIPE beat stream, DLLP priority at
// TLP boundaries with a bounded burst so a waiting TLP cannot starve.
//   state    | meaning
//   ARB_IDLE | at a TLP boundary, DLLP or TLP sop may be granted
//   ARB_TLP  | locked inside a multi-beat TLP until its eop beat
module dll_tx_arbiter
  import dll_tx_arbiter_pkg::*;
#(
  parameter int DATA_W         = DLL_BEAT_W,
  parameter int DLLP_MAX_BURST = 4
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic [1:0]        dlcm_state_i,
  input  logic              dllp_valid_i,
  input  logic [DATA_W-1:0] dllp_data_i,
  output logic              arb_ready_o,
  input  logic              tlp_valid_i,
  input  logic [DATA_W-1:0] tlp_data_i,
  input  logic              tlp_sop_i,
  input  logic              tlp_eop_i,
  output logic              tlp_ready_o,
  input  logic              pipe_ready_i,
  output logic              dll2pipe_valid_o,
  output logic [DATA_W-1:0] dll2pipe_data_o,
  output logic              err_o
);

  localparam logic [3:0] MAX_BURST = 4'(DLLP_MAX_BURST);

  arb_state_t        state;
  logic [3:0]        burst_cnt;
  logic              stage_ready;
  logic              dllp_ok;
  logic              tlp_ok;
  logic              orphan;
  logic              dllp_gnt;
  logic              tlp_gnt;
  logic              drop;
  logic [DATA_W-1:0] load_data;

  assign dllp_ok = dllp_valid_i && (dlcm_state_i != DL_INACTIVE);
  assign tlp_ok  = tlp_valid_i && tlp_sop_i && (dlcm_state_i == DL_ACTIVE);
  assign orphan  = tlp_valid_i && !tlp_sop_i;

  // Orphan drops bypass stage_ready: they never occupy the output stage.
  always_comb begin
    dllp_gnt = 1'b0;
    tlp_gnt  = 1'b0;
    drop     = 1'b0;
    if (srst_n) begin
      if (state == ARB_IDLE) begin
        if (stage_ready && dllp_ok && (!tlp_ok || burst_cnt < MAX_BURST))
          dllp_gnt = 1'b1;
        else if (stage_ready && tlp_ok)
          tlp_gnt = 1'b1;
        else if (orphan)
          drop = 1'b1;
      end else begin
        tlp_gnt = tlp_valid_i && stage_ready;
      end
    end
  end

  assign arb_ready_o = dllp_gnt;
  assign tlp_ready_o = tlp_gnt || drop;
  assign load_data   = dllp_gnt ? dllp_data_i : tlp_data_i;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= ARB_IDLE;
      burst_cnt <= '0;
      err_o     <= 1'b0;
    end else begin
      err_o <= drop;
      if (state == ARB_IDLE) begin
        if (tlp_gnt) begin
          burst_cnt <= '0;
          if (!tlp_eop_i) state <= ARB_TLP;
        end else if (!tlp_ok) begin
          burst_cnt <= '0;
        end else if (dllp_gnt && burst_cnt < MAX_BURST) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else if (tlp_gnt && tlp_eop_i) begin
        state <= ARB_IDLE;
      end
    end
  end

  dll_pipe_out_reg #(.W(DATA_W)) u_out_reg (
    .sclk          (sclk),
    .srst_n        (srst_n),
    .load_i        (dllp_gnt || tlp_gnt),
    .data_i        (load_data),
    .pipe_ready_i  (pipe_ready_i),
    .stage_ready_o (stage_ready),
    .valid_o       (dll2pipe_valid_o),
    .data_o        (dll2pipe_data_o)
  );

endmodule
